// File: rtl/pcie_msi_tlp_gen_if.sv
// MSI request/acknowledge handshake plus the Avalon-ST TX source port of the MSI TLP generator.
// The slave view belongs to the generator; the master view belongs to the requester and TX arbiter side.
interface pcie_msi_tlp_gen_if;
  logic        app_msi_req;
  logic [4:0]  app_msi_num;
  logic [2:0]  app_msi_tc;
  logic        app_msi_ack;

  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;
  logic        tx_empty;
  logic [63:0] tx_data;

  modport slave (
    input  app_msi_req, app_msi_num, app_msi_tc, tx_ready,
    output app_msi_ack, tx_valid, tx_sop, tx_eop, tx_empty, tx_data
  );

  modport master (
    output app_msi_req, app_msi_num, app_msi_tc, tx_ready,
    input  app_msi_ack, tx_valid, tx_sop, tx_eop, tx_empty, tx_data
  );
endinterface

// File: rtl/pcie_msi_tlp_gen.sv
// Completer of the app_msi_req/app_msi_ack handshake. It turns one MSI request into a 3DW or 4DW
// Memory Write TLP on a 64-bit Avalon-ST source, then acknowledges the requester.
module pcie_msi_tlp_gen #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pcie_msi_tlp_gen_if.slave    bus,
  input  logic                 cfg_msi_en,
  input  logic [2:0]           cfg_msi_mme,
  input  logic [63:0]          cfg_msi_addr,
  input  logic [15:0]          cfg_msi_data,
  input  logic [15:0]          cfg_req_id,
  output logic [CNT_W-1:0]     msi_sent,
  output logic [CNT_W-1:0]     msi_dropped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT0,
    S_BEAT1,
    S_BEAT2,
    S_ACK,
    S_HOLD
  } state_e;

  state_e             state_q;
  logic               is4_q;
  logic [63:0]        beat1_q;
  logic [63:0]        beat2_q;
  logic               tx_valid_q;
  logic               tx_sop_q;
  logic               tx_eop_q;
  logic               tx_empty_q;
  logic [63:0]        tx_data_q;
  logic               ack_q;
  logic [CNT_W-1:0]   sent_q;
  logic [CNT_W-1:0]   dropped_q;
  logic [CNT_W-1:0]   sent_d;
  logic [CNT_W-1:0]   dropped_d;

  // TLP fields built straight from the live inputs; they are captured only on the sampling edge.
  logic               is4_c;
  logic [2:0]         m_c;
  logic [4:0]         mask_c;
  logic [15:0]        data_c;
  logic [31:0]        pl_c;
  logic [31:0]        dw0_c;
  logic [31:0]        dw1_c;
  logic [31:0]        addr_lo_c;
  logic [63:0]        beat0_c;
  logic [63:0]        beat1_c;
  logic [63:0]        beat2_c;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^cfg_msi_addr[1:0];

  always_comb begin
    is4_c     = |cfg_msi_addr[63:32];
    m_c       = (cfg_msi_mme > 3'd5) ? 3'd5 : cfg_msi_mme;
    mask_c    = 5'((6'd1 << m_c) - 6'd1);
    data_c    = {cfg_msi_data[15:5],
                 (cfg_msi_data[4:0] & ~mask_c) | (bus.app_msi_num & mask_c)};
    pl_c      = {16'h0000, data_c};
    // Fmt 010/011, Type 0, TC, TD/EP/Attr/AT all zero, Length 1.
    dw0_c     = {2'b01, is4_c, 5'b00000, 1'b0, bus.app_msi_tc, 4'b0000,
                 1'b0, 1'b0, 2'b00, 2'b00, 10'd1};
    dw1_c     = {cfg_req_id, 8'h00, 4'h0, 4'hF};
    addr_lo_c = {cfg_msi_addr[31:2], 2'b00};
    beat0_c   = {dw1_c, dw0_c};
    beat1_c   = is4_c ? {addr_lo_c, cfg_msi_addr[63:32]} : {pl_c, addr_lo_c};
    beat2_c   = {32'h0000_0000, pl_c};
  end

  always_comb begin
    sent_d    = (&sent_q)    ? sent_q    : sent_q + CNT_W'(1);
    dropped_d = (&dropped_q) ? dropped_q : dropped_q + CNT_W'(1);
  end

  // NOTE: asynchronous reset drops tx_valid the instant reset rises, aborting any packet in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is4_q      <= 1'b0;
      beat1_q    <= '0;
      beat2_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_empty_q <= 1'b0;
      tx_data_q  <= '0;
      ack_q      <= 1'b0;
      sent_q     <= '0;
      dropped_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every register sees pre-edge values of the others.
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.app_msi_req) begin
            if (cfg_msi_en) begin
              is4_q      <= is4_c;
              beat1_q    <= beat1_c;
              beat2_q    <= beat2_c;
              tx_valid_q <= 1'b1;
              tx_sop_q   <= 1'b1;
              tx_eop_q   <= 1'b0;
              tx_empty_q <= 1'b0;
              tx_data_q  <= beat0_c;
              state_q    <= S_BEAT0;
            end else begin
              dropped_q  <= dropped_d;
              ack_q      <= 1'b1;
              state_q    <= S_ACK;
            end
          end
        end

        S_BEAT0: begin
          if (bus.tx_ready) begin
            tx_sop_q   <= 1'b0;
            tx_eop_q   <= ~is4_q;
            tx_empty_q <= 1'b0;
            tx_data_q  <= beat1_q;
            state_q    <= S_BEAT1;
          end
        end

        S_BEAT1, S_BEAT2: begin
          if (bus.tx_ready) begin
            if (tx_eop_q) begin
              tx_valid_q <= 1'b0;
              tx_eop_q   <= 1'b0;
              tx_empty_q <= 1'b0;
              tx_data_q  <= '0;
              sent_q     <= sent_d;
              ack_q      <= 1'b1;
              state_q    <= S_ACK;
            end else begin
              tx_eop_q   <= 1'b1;
              tx_empty_q <= 1'b1;
              tx_data_q  <= beat2_q;
              state_q    <= S_BEAT2;
            end
          end
        end

        S_ACK:   state_q <= S_HOLD;
        // Requester gets one cycle to drop or retarget req before it is sampled again.
        S_HOLD:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.app_msi_ack = ack_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_sop      = tx_sop_q;
  assign bus.tx_eop      = tx_eop_q;
  assign bus.tx_empty    = tx_empty_q;
  assign bus.tx_data     = tx_data_q;
  assign msi_sent        = sent_q;
  assign msi_dropped     = dropped_q;

endmodule

// File: tb/tb_pcie_msi_tlp_gen.sv
// Directed bench for pcie_msi_tlp_gen: a table of hand-computed TLPs with ready held high, followed by
// sequences for backpressure, disabled MSI, back-to-back requests, reset mid-packet and counter saturation.
module tb_pcie_msi_tlp_gen;
  localparam int CNT_W = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_msi_en;
  logic [2:0]        cfg_msi_mme;
  logic [63:0]       cfg_msi_addr;
  logic [15:0]       cfg_msi_data;
  logic [15:0]       cfg_req_id;
  logic [CNT_W-1:0]  msi_sent;
  logic [CNT_W-1:0]  msi_dropped;

  pcie_msi_tlp_gen_if bus_if ();

  pcie_msi_tlp_gen #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_if),
    .cfg_msi_en   (cfg_msi_en),
    .cfg_msi_mme  (cfg_msi_mme),
    .cfg_msi_addr (cfg_msi_addr),
    .cfg_msi_data (cfg_msi_data),
    .cfg_req_id   (cfg_req_id),
    .msi_sent     (msi_sent),
    .msi_dropped  (msi_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [15:0] data;
    logic [2:0]  mme;
    logic [4:0]  num;
    logic [2:0]  tc;
    logic [15:0] rid;
    logic        is4;
    logic [63:0] b0;
    logic [63:0] b1;
    logic [63:0] b2;
  } vec_t;

  vec_t             vecs [5];
  int               n_checks = 0;
  int               n_errors = 0;
  logic [CNT_W-1:0] exp_sent;
  logic [CNT_W-1:0] exp_dropped;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  task automatic check_beat(input string name, input logic sop, input logic eop,
                            input logic empty, input logic [63:0] data);
    check(name, 128'({bus_if.tx_valid, bus_if.tx_sop, bus_if.tx_eop, bus_if.tx_empty, bus_if.tx_data}),
          128'({1'b1, sop, eop, empty, data}));
  endtask

  task automatic check_idle(input string name, input logic ack);
    check(name, 128'({bus_if.app_msi_ack, bus_if.tx_valid}), 128'({ack, 1'b0}));
  endtask

  task automatic drive_cfg(input vec_t v);
    cfg_msi_en         = 1'b1;
    cfg_msi_addr       = v.addr;
    cfg_msi_data       = v.data;
    cfg_msi_mme        = v.mme;
    cfg_req_id         = v.rid;
    bus_if.app_msi_num = v.num;
    bus_if.app_msi_tc  = v.tc;
  endtask

  // Starts in an IDLE cycle with ready high; returns in the next IDLE cycle.
  task automatic run_vec(input vec_t v, input string tag);
    drive_cfg(v);
    bus_if.app_msi_req = 1'b1;
    tick();
    // Scramble every input after the sampling edge: the TLP must come from the snapshot.
    cfg_msi_en         = 1'b0;
    cfg_msi_addr       = 64'hDEAD_BEEF_C0DE_F00C;
    cfg_msi_data       = 16'hFFFF;
    cfg_msi_mme        = 3'd0;
    cfg_req_id         = 16'h0000;
    bus_if.app_msi_num = 5'd0;
    bus_if.app_msi_tc  = 3'd0;
    check_beat({tag, "_beat0"}, 1'b1, 1'b0, 1'b0, v.b0);
    tick();
    if (v.is4) begin
      check_beat({tag, "_beat1"}, 1'b0, 1'b0, 1'b0, v.b1);
      tick();
      check_beat({tag, "_beat2"}, 1'b0, 1'b1, 1'b1, v.b2);
    end else begin
      check_beat({tag, "_beat1"}, 1'b0, 1'b1, 1'b0, v.b1);
    end
    tick();
    exp_sent = sat_inc(exp_sent);
    check_idle({tag, "_ack"}, 1'b1);
    check({tag, "_sent"}, 128'(msi_sent), 128'(exp_sent));
    bus_if.app_msi_req = 1'b0;
    tick();
    check_idle({tag, "_hold"}, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfers;
    int acks;
    int ack_cycle;

    // addr, data, mme, num, tc, rid, is4, beat0, beat1, beat2
    vecs[0] = '{64'h0000_0000_FEE0_0000, 16'h4020, 3'd0, 5'd3,  3'd0, 16'h0100, 1'b0,
                64'h0100_000F_4000_0001, 64'h0000_4020_FEE0_0000, 64'h0};
    vecs[1] = '{64'h0000_0001_2345_6780, 16'hABC0, 3'd3, 5'd5,  3'd0, 16'h0100, 1'b1,
                64'h0100_000F_6000_0001, 64'h2345_6780_0000_0001, 64'h0000_0000_0000_ABC5};
    vecs[2] = '{64'h0000_0000_FEE0_1003, 16'hFFFF, 3'd7, 5'h0A, 3'd7, 16'hBEEF, 1'b0,
                64'hBEEF_000F_4070_0001, 64'h0000_FFEA_FEE0_1000, 64'h0};
    vecs[3] = '{64'hFFFF_FFFF_0000_0004, 16'h1234, 3'd1, 5'h1F, 3'd3, 16'h0A0B, 1'b1,
                64'h0A0B_000F_6030_0001, 64'h0000_0004_FFFF_FFFF, 64'h0000_0000_0000_1235};
    vecs[4] = '{64'h0000_0000_0000_0010, 16'h5A5A, 3'd5, 5'h15, 3'd1, 16'h0001, 1'b0,
                64'h0001_000F_4010_0001, 64'h0000_5A55_0000_0010, 64'h0};

    reset              = 1'b1;
    bus_if.app_msi_req = 1'b0;
    bus_if.tx_ready    = 1'b1;
    drive_cfg(vecs[0]);
    exp_sent    = '0;
    exp_dropped = '0;
    #1;
    check("reset_outputs", 128'({bus_if.app_msi_ack, bus_if.tx_valid, bus_if.tx_sop, bus_if.tx_eop,
                                 bus_if.tx_empty, bus_if.tx_data}), 128'(0));
    check("reset_counters", 128'({msi_sent, msi_dropped}), 128'(0));
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_idle("idle_no_req", 1'b0);

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: ready pulses once per beat after three stalled cycles.
    drive_cfg(vecs[0]);
    bus_if.tx_ready    = 1'b0;
    bus_if.app_msi_req = 1'b1;
    tick();
    xfers     = 0;
    acks      = 0;
    ack_cycle = 0;
    for (int c = 1; c <= 12; c++) begin
      bus_if.tx_ready = (c == 4 || c == 8);
      if (c == 9) bus_if.app_msi_req = 1'b0;
      if (c <= 4) check_beat($sformatf("bp_beat0_c%0d", c), 1'b1, 1'b0, 1'b0, vecs[0].b0);
      else if (c <= 8) check_beat($sformatf("bp_beat1_c%0d", c), 1'b0, 1'b1, 1'b0, vecs[0].b1);
      if (bus_if.tx_valid && bus_if.tx_ready) xfers++;
      if (bus_if.app_msi_ack) begin
        acks++;
        ack_cycle = c;
      end
      tick();
    end
    bus_if.tx_ready = 1'b1;
    exp_sent = sat_inc(exp_sent);
    check("bp_transfers", 128'(xfers), 128'(2));
    check("bp_ack_count", 128'(acks), 128'(1));
    check("bp_ack_cycle", 128'(ack_cycle), 128'(9));
    check("bp_sent", 128'(msi_sent), 128'(exp_sent));

    // MSI disabled: acked without a TLP; nine drops push the 3-bit counter into saturation.
    for (int k = 0; k < 9; k++) begin
      drive_cfg(vecs[0]);
      cfg_msi_en         = 1'b0;
      bus_if.app_msi_num = 5'd1;
      bus_if.app_msi_req = 1'b1;
      tick();
      exp_dropped = sat_inc(exp_dropped);
      check_idle($sformatf("dis%0d_ack", k), 1'b1);
      check($sformatf("dis%0d_dropped", k), 128'(msi_dropped), 128'(exp_dropped));
      check($sformatf("dis%0d_sent", k), 128'(msi_sent), 128'(exp_sent));
      bus_if.app_msi_req = 1'b0;
      tick();
      check_idle($sformatf("dis%0d_hold", k), 1'b0);
      tick();
    end
    check("dropped_saturated", 128'(msi_dropped), 128'({CNT_W{1'b1}}));

    // Back-to-back: req stays high across the ack, num moves from 0 to 2 during HOLD.
    drive_cfg(vecs[0]);
    cfg_msi_data       = 16'hC0DF;
    cfg_msi_mme        = 3'd2;
    bus_if.app_msi_num = 5'd0;
    bus_if.app_msi_req = 1'b1;
    tick();
    check_beat("b2b_first_sop", 1'b1, 1'b0, 1'b0, vecs[0].b0);
    tick();
    check_beat("b2b_first_eop", 1'b0, 1'b1, 1'b0, 64'h0000_C0DC_FEE0_0000);
    tick();
    exp_sent = sat_inc(exp_sent);
    check_idle("b2b_first_ack", 1'b1);
    check("b2b_first_sent", 128'(msi_sent), 128'(exp_sent));
    bus_if.app_msi_num = 5'd2;
    tick();
    check_idle("b2b_hold", 1'b0);
    tick();
    check_idle("b2b_idle_sample", 1'b0);
    tick();
    check_beat("b2b_second_sop", 1'b1, 1'b0, 1'b0, vecs[0].b0);
    tick();
    check_beat("b2b_second_eop", 1'b0, 1'b1, 1'b0, 64'h0000_C0DE_FEE0_0000);
    tick();
    exp_sent = sat_inc(exp_sent);
    check_idle("b2b_second_ack", 1'b1);
    check("sent_saturated", 128'(msi_sent), 128'(exp_sent));
    bus_if.app_msi_req = 1'b0;
    tick();
    tick();

    // Reset while beat1 is stalled.
    drive_cfg(vecs[0]);
    bus_if.tx_ready    = 1'b0;
    bus_if.app_msi_req = 1'b1;
    tick();
    check_beat("rst_beat0", 1'b1, 1'b0, 1'b0, vecs[0].b0);
    bus_if.tx_ready = 1'b1;
    tick();
    bus_if.tx_ready = 1'b0;
    check_beat("rst_beat1", 1'b0, 1'b1, 1'b0, vecs[0].b1);
    tick();
    check_beat("rst_beat1_stall", 1'b0, 1'b1, 1'b0, vecs[0].b1);
    reset = 1'b1;
    #1;
    check("rst_abort_outputs", 128'({bus_if.app_msi_ack, bus_if.tx_valid, bus_if.tx_sop, bus_if.tx_eop}),
          128'(0));
    check("rst_abort_counters", 128'({msi_sent, msi_dropped}), 128'(0));
    bus_if.app_msi_req = 1'b0;
    exp_sent    = '0;
    exp_dropped = '0;
    tick();
    tick();
    reset           = 1'b0;
    bus_if.tx_ready = 1'b1;
    tick();
    check_idle("rst_no_ack", 1'b0);
    run_vec(vecs[0], "post_rst");
    check("post_rst_dropped", 128'(msi_dropped), 128'(exp_dropped));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
